// File: rtl/zigzag_pkg.sv
// zigzag_pkg
// Shared definitions for the forward and inverse zigzag reorder blocks.
// Holds the default geometry (32-bit coefficients, 8x8 blocks), the width
// of the scan index, the bank-state enum used by the ping-pong buffers, and
// the 8x8 scan table mapping a zigzag scan position to its natural
// row-major position (r*8+c).
package zigzag_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_DATA_DEPTH  = 8;
    localparam int DEFAULT_PIXEL_COUNT = DEFAULT_DATA_DEPTH * DEFAULT_DATA_DEPTH;
    localparam int IDX_WIDTH           = 6;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Entry k is the natural row-major position of zigzag scan position k.
    localparam logic [IDX_WIDTH-1:0] ZZ_TO_NAT [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/izz_bank.sv
// izz_bank
// One 64-entry coefficient bank for the inverse zigzag ping-pong buffer.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset (clears the bank)
//   wr_en      - write wr_data into entry wr_addr this cycle
//   wr_addr    - natural row-major entry index (0..63)
//   wr_data    - coefficient to store
//   clear      - zero all entries this cycle (block released downstream)
//   rd_matrix  - flat read-out, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
module izz_bank
    import zigzag_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int PIXEL_COUNT = DEFAULT_PIXEL_COUNT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [IDX_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              clear,
    output logic [DATA_WIDTH*PIXEL_COUNT-1:0] rd_matrix
);

    logic [DATA_WIDTH*PIXEL_COUNT-1:0] entries;

    // Clearing the whole bank on release is what makes an early-terminated
    // block read back with zeros after its last coefficient, so the clear
    // takes priority. The top never writes and clears the same bank in one
    // cycle (a bank being written is never FULL, a bank being cleared is).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
        end else if (clear) begin
            entries <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < PIXEL_COUNT; i++) begin
                if (wr_addr == IDX_WIDTH'(i)) begin
                    entries[i*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                end
            end
        end
    end

    assign rd_matrix = entries;

endmodule

// File: rtl/izigzag_stream.sv
// izigzag_stream
// Streaming inverse zigzag reorder. Coefficients arrive one per cycle in
// zigzag scan order and leave as a complete 8x8 block in natural row-major
// order. Two ping-pong banks let one block fill while the other waits for
// downstream; in_last ends a block early and the remaining positions read 0.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   in_data     - coefficient in zigzag order
//   in_valid    - in_data is valid
//   in_last     - this coefficient ends the block (sampled on handshake)
//   in_ready    - the write bank can accept a coefficient
//   out_matrix  - natural-order block, element r*8+c at
//                 [(r*8+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   - out_matrix holds a complete block
//   out_ready   - downstream accepts the block
module izigzag_stream
    import zigzag_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DATA_DEPTH  = DEFAULT_DATA_DEPTH,
    parameter int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [DATA_WIDTH*PIXEL_COUNT-1:0] out_matrix,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PIXEL_COUNT - 1);

    bank_state_t                       bank_state      [2];
    bank_state_t                       bank_state_next [2];
    logic                              wr_bank;
    logic                              wr_bank_next;
    logic                              rd_bank;
    logic                              rd_bank_next;
    logic [IDX_WIDTH-1:0]              idx;
    logic [IDX_WIDTH-1:0]              idx_next;
    logic                              in_hs;
    logic                              out_hs;
    logic                              block_done;
    logic [1:0]                        bank_wr_en;
    logic [1:0]                        bank_clear;
    logic [DATA_WIDTH*PIXEL_COUNT-1:0] bank_data [2];

    // Ready/valid come straight from the registered bank states, so neither
    // depends combinationally on the other side's handshake inputs.
    assign in_ready   = (bank_state[wr_bank] != FULL);
    assign out_valid  = (bank_state[rd_bank] == FULL);
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign block_done = in_hs && ((idx == LAST_IDX) || in_last);

    assign bank_wr_en[0] = in_hs && !wr_bank;
    assign bank_wr_en[1] = in_hs &&  wr_bank;
    assign bank_clear[0] = out_hs && !rd_bank;
    assign bank_clear[1] = out_hs &&  rd_bank;

    assign out_matrix = rd_bank ? bank_data[1] : bank_data[0];

    izz_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PIXEL_COUNT (PIXEL_COUNT)
    ) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_wr_en[0]),
        .wr_addr   (ZZ_TO_NAT[idx]),
        .wr_data   (in_data),
        .clear     (bank_clear[0]),
        .rd_matrix (bank_data[0])
    );

    izz_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PIXEL_COUNT (PIXEL_COUNT)
    ) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_wr_en[1]),
        .wr_addr   (ZZ_TO_NAT[idx]),
        .wr_data   (in_data),
        .clear     (bank_clear[1]),
        .rd_matrix (bank_data[1])
    );

    // Pointer and bank-state registers. Reset discards any partial block and
    // restarts the scan at index 0 on bank 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            idx           <= '0;
        end else begin
            bank_state[0] <= bank_state_next[0];
            bank_state[1] <= bank_state_next[1];
            wr_bank       <= wr_bank_next;
            rd_bank       <= rd_bank_next;
            idx           <= idx_next;
        end
    end

    // Next-state logic. A write and a release can land in the same cycle;
    // they always target different banks (the write bank is not FULL, the
    // read bank is), so both updates are applied independently.
    always_comb begin
        bank_state_next[0] = bank_state[0];
        bank_state_next[1] = bank_state[1];
        wr_bank_next       = wr_bank;
        rd_bank_next       = rd_bank;
        idx_next           = idx;

        if (in_hs) begin
            if (block_done) begin
                bank_state_next[wr_bank] = FULL;
                idx_next                 = '0;
                wr_bank_next             = !wr_bank;
            end else begin
                bank_state_next[wr_bank] = FILLING;
                idx_next                 = idx + IDX_WIDTH'(1);
            end
        end

        if (out_hs) begin
            bank_state_next[rd_bank] = EMPTY;
            rd_bank_next             = !rd_bank;
        end
    end

endmodule

// File: tb/tb_izigzag_stream.sv
// tb_izigzag_stream
// Directed self-checking bench for izigzag_stream: reset state, full block,
// early end with zero fill, backpressure, sustained throughput, reset in the
// middle of a block and a round trip of random natural-order matrices.
module tb_izigzag_stream;

    localparam int DW = 32;
    localparam int N  = 64;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [N*DW-1:0] out_matrix;
    logic            out_valid;
    logic            out_ready;

    int checks;
    int errors;
    int zz_order [N];

    izigzag_stream #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_matrix (out_matrix),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the summary line");
        $fatal(1, "[TB] watchdog");
    end

    // Zigzag scan order derived by walking the anti-diagonals of the 8x8
    // block, alternating direction on each diagonal.
    task automatic build_order();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_order[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_order[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endtask

    function automatic int first_diff(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        for (int i = 0; i < N; i++) begin
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        end
        return 0;
    endfunction

    // Present one coefficient and hold it until the DUT accepts it.
    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int   waited = 0;
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 300);
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_beat timeout: in_ready stayed %b, required 1", rdy);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b0;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_matrix !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out_matrix elem %0d got %h want 0",
                     first_diff(out_matrix, '0), out_matrix[first_diff(out_matrix, '0)*DW +: DW]);
        end
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b0;
    endtask

    task automatic test_full_block();
        int elem [9] = '{0, 1, 8, 16, 9, 2, 63, 7, 56};
        int want [9] = '{1, 2, 3, 4, 5, 6, 64, 29, 36};
        out_ready = 1'b1;
        for (int k = 0; k < 63; k++) send_beat(DW'(k + 1), 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_block_early_valid got %b want 0", out_valid);
        end
        send_beat(DW'(64), 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_block_valid got %b want 1", out_valid);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (out_matrix[elem[i]*DW +: DW] !== DW'(want[i])) begin
                errors++;
                $display("[TB] FAIL full_block_elem%0d got %0d want %0d",
                         elem[i], out_matrix[elem[i]*DW +: DW], want[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_block_valid_pulse got %b want 0", out_valid);
        end
    endtask

    task automatic test_early_end();
        logic [N*DW-1:0] exp;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) send_beat(32'hAB, 1'b0);
        send_beat(32'h10, 1'b0);
        send_beat(32'h20, 1'b1);
        exp            = '0;
        exp[0 +: DW]   = 32'h10;
        exp[DW +: DW]  = 32'h20;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL early_end_valid got %b want 1", out_valid);
        end
        checks++;
        if (out_matrix !== exp) begin
            errors++;
            $display("[TB] FAIL early_end_matrix elem %0d got %h want %h", first_diff(out_matrix, exp),
                     out_matrix[first_diff(out_matrix, exp)*DW +: DW], exp[first_diff(out_matrix, exp)*DW +: DW]);
        end
        for (int k = 0; k < N; k++) send_beat(32'hFF, 1'b0);
        exp = {N{32'h0000_00FF}};
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_early_valid got %b want 1", out_valid);
        end
        checks++;
        if (out_matrix !== exp) begin
            errors++;
            $display("[TB] FAIL after_early_matrix elem %0d got %h want %h", first_diff(out_matrix, exp),
                     out_matrix[first_diff(out_matrix, exp)*DW +: DW], exp[first_diff(out_matrix, exp)*DW +: DW]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [N*DW-1:0] blk1;
        logic [N*DW-1:0] blk2;
        int              accepted = 0;
        logic            rdy;
        apply_reset();
        for (int k = 0; k < N; k++) begin
            blk1[zz_order[k]*DW +: DW] = DW'(1000 + k);
            blk2[zz_order[k]*DW +: DW] = DW'(1064 + k);
        end
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 135 && accepted < 130; cyc++) begin
            in_valid = 1'b1;
            in_data  = DW'(1000 + accepted);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != 128) begin
            errors++;
            $display("[TB] FAIL bp_accepted got %0d want 128", accepted);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready_low got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_matrix !== blk1) begin
            errors++;
            $display("[TB] FAIL bp_block1 valid %b elem %0d got %0d want %0d", out_valid, first_diff(out_matrix, blk1),
                     out_matrix[first_diff(out_matrix, blk1)*DW +: DW], blk1[first_diff(out_matrix, blk1)*DW +: DW]);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_matrix !== blk1) begin
            errors++;
            $display("[TB] FAIL bp_block1_stable elem %0d got %0d want %0d", first_diff(out_matrix, blk1),
                     out_matrix[first_diff(out_matrix, blk1)*DW +: DW], blk1[first_diff(out_matrix, blk1)*DW +: DW]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_matrix !== blk2) begin
            errors++;
            $display("[TB] FAIL bp_block2 valid %b elem %0d got %0d want %0d", out_valid, first_diff(out_matrix, blk2),
                     out_matrix[first_diff(out_matrix, blk2)*DW +: DW], blk2[first_diff(out_matrix, blk2)*DW +: DW]);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_in_ready_back got %b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   drops = 0;
        int   pulses = 0;
        int   bad_gaps = 0;
        int   last_pulse = 0;
        logic rdy;
        apply_reset();
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 640; cyc++) begin
            in_valid = 1'b1;
            in_data  = DW'(cyc);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (!rdy) drops++;
            if (out_valid) begin
                pulses++;
                if (cyc - last_pulse != 64) bad_gaps++;
                last_pulse = cyc;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (drops != 0) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready_drops got %0d want 0", drops);
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("[TB] FAIL b2b_out_valid_pulses got %0d want 10", pulses);
        end
        checks++;
        if (bad_gaps != 0) begin
            errors++;
            $display("[TB] FAIL b2b_pulse_spacing bad gaps %0d want 0", bad_gaps);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_block();
        logic [N*DW-1:0] exp;
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 30; k++) send_beat(DW'(7), 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_flags out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end
        checks++;
        if (out_matrix !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_matrix elem %0d got %h want 0",
                     first_diff(out_matrix, '0), out_matrix[first_diff(out_matrix, '0)*DW +: DW]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp[zz_order[k]*DW +: DW] = DW'(500 + k);
            send_beat(DW'(500 + k), 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_matrix !== exp) begin
            errors++;
            $display("[TB] FAIL mid_reset_block valid %b elem %0d got %0d want %0d", out_valid, first_diff(out_matrix, exp),
                     out_matrix[first_diff(out_matrix, exp)*DW +: DW], exp[first_diff(out_matrix, exp)*DW +: DW]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_trip();
        logic [N*DW-1:0] mat;
        apply_reset();
        out_ready = 1'b1;
        for (int m = 0; m < 20; m++) begin
            for (int e = 0; e < N; e++) mat[e*DW +: DW] = $urandom;
            for (int k = 0; k < N; k++) begin
                send_beat(mat[zz_order[k]*DW +: DW], (m % 2 == 1) && (k == N - 1));
            end
            checks++;
            if (out_valid !== 1'b1 || out_matrix !== mat) begin
                errors++;
                $display("[TB] FAIL round_trip_%0d valid %b elem %0d got %h want %h", m, out_valid, first_diff(out_matrix, mat),
                         out_matrix[first_diff(out_matrix, mat)*DW +: DW], mat[first_diff(out_matrix, mat)*DW +: DW]);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        build_order();
        $display("[TB] starting izigzag_stream bench");
        test_reset();
        test_full_block();
        test_early_end();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_block();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
